// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level logic for an asynchronous FIFO.
// Synchronizes the Gray write pointer into the read domain and produces the flags.
module fifo_rptr_empty #(
    parameter int ADDRESS  = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic               R_CLK,
    input  logic               R_RST,
    input  logic               R_INC,
    input  logic [ADDRESS:0]   W_PTR_ASYNC,
    output logic [ADDRESS-1:0] R_ADDR,
    output logic [ADDRESS:0]   R_PTR,
    output logic               R_EMPTY,
    output logic               R_ALMOST_EMPTY,
    output logic [ADDRESS:0]   R_LEVEL,
    output logic               R_UNDERFLOW
);

    localparam logic [ADDRESS:0] AE_THRESH = (ADDRESS+1)'(AE_LEVEL);

    logic [ADDRESS:0] rq1_reg;
    logic [ADDRESS:0] rq2_reg;
    logic [ADDRESS:0] rbin_reg;
    logic [ADDRESS:0] rbin_next;
    logic [ADDRESS:0] rgray_next;
    logic [ADDRESS:0] wbin_s;
    logic [ADDRESS:0] level_next;
    logic             pop;

    // Plain two-stage synchronizer for the Gray write pointer.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rq1_reg <= '0;
            rq2_reg <= '0;
        end else begin
            rq1_reg <= W_PTR_ASYNC;
            rq2_reg <= rq1_reg;
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi <= ADDRESS; gi++) begin : g_gray2bin
            assign wbin_s[gi] = ^rq2_reg[ADDRESS:gi];
        end
    endgenerate

    always_comb begin
        pop        = R_INC & ~R_EMPTY;
        rbin_next  = rbin_reg + (ADDRESS+1)'(pop);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        level_next = wbin_s - rbin_next;
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rbin_reg       <= '0;
            R_PTR          <= '0;
            R_EMPTY        <= 1'b1;
            R_ALMOST_EMPTY <= 1'b1;
            R_LEVEL        <= '0;
            R_UNDERFLOW    <= 1'b0;
        end else begin
            rbin_reg       <= rbin_next;
            R_PTR          <= rgray_next;
            R_EMPTY        <= (rgray_next == rq2_reg);
            R_LEVEL        <= level_next;
            R_ALMOST_EMPTY <= (level_next <= AE_THRESH);
            R_UNDERFLOW    <= R_INC & R_EMPTY;
        end
    end

    assign R_ADDR = rbin_reg[ADDRESS-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Scoreboard bench for fifo_rptr_empty: stimulus queues expected outputs,
// monitors pop and compare after each clock edge or asynchronous reset event.
module tb_fifo_rptr_empty;

    logic       clk;
    logic       rst;
    logic       inc;
    logic [3:0] wptr;
    logic [2:0] r_addr;
    logic [3:0] r_ptr;
    logic       r_empty;
    logic       r_ae;
    logic [3:0] r_level;
    logic       r_uf;

    fifo_rptr_empty #(.ADDRESS(3), .AE_LEVEL(1)) dut (
        .R_CLK          (clk),
        .R_RST          (rst),
        .R_INC          (inc),
        .W_PTR_ASYNC    (wptr),
        .R_ADDR         (r_addr),
        .R_PTR          (r_ptr),
        .R_EMPTY        (r_empty),
        .R_ALMOST_EMPTY (r_ae),
        .R_LEVEL        (r_level),
        .R_UNDERFLOW    (r_uf)
    );

    typedef struct {
        string      name;
        logic [3:0] ptr;
        logic [2:0] addr;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic       uf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event async_ev;
    logic [3:0] gray_tab [0:8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, got, want);
        end
    endtask

    task automatic check(input exp_t e);
        cmp(e.name, "R_PTR",          32'(r_ptr),   32'(e.ptr));
        cmp(e.name, "R_ADDR",         32'(r_addr),  32'(e.addr));
        cmp(e.name, "R_EMPTY",        32'(r_empty), 32'(e.empty));
        cmp(e.name, "R_ALMOST_EMPTY", 32'(r_ae),    32'(e.ae));
        cmp(e.name, "R_LEVEL",        32'(r_level), 32'(e.level));
        cmp(e.name, "R_UNDERFLOW",    32'(r_uf),    32'(e.uf));
        $display("txn %-14s ptr=%b addr=%0d empty=%b ae=%b level=%0d uf=%b",
                 e.name, r_ptr, r_addr, r_empty, r_ae, r_level, r_uf);
    endtask

    task automatic push_exp(input string nm, input logic [3:0] p, input logic [2:0] a,
                            input logic e, input logic ae, input logic [3:0] l, input logic u);
        exp_t t;
        t.name = nm; t.ptr = p; t.addr = a; t.empty = e;
        t.ae = ae; t.level = l; t.uf = u;
        q.push_back(t);
    endtask

    task automatic cyc(input logic i, input logic [3:0] w);
        @(negedge clk);
        inc  = i;
        wptr = w;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst  = 1'b1;
        inc  = 1'b0;
        wptr = 4'b0000;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // Edge monitor: one queued expectation per rising edge that has one.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check(q.pop_front());
        end
    end

    // Asynchronous-reset monitor, triggered between clock edges.
    initial begin
        forever begin
            @(async_ev);
            #1;
            if (q.size() > 0) check(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
        rst  = 1'b0;
        inc  = 1'b0;
        wptr = 4'b0000;
        #1;
        rst = 1'b1;
        inc = 1'b1;
        #1;
        push_exp("rst_async", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        -> async_ev;
        cyc(1'b1, 4'b0000); push_exp("rst_hold1", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("rst_hold2", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        inc = 1'b0;

        // Synchronizer latency: visible on the third edge, not the second.
        cyc(1'b0, 4'b0001); push_exp("sync_e1",   4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b0001); push_exp("sync_e2",   4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b0001); push_exp("sync_e3",   4'b0000, 3'd0, 1'b0, 1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'b0001); push_exp("last_pop",  4'b0001, 3'd1, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 4'b0001); push_exp("underflow", 4'b0001, 3'd1, 1'b1, 1'b1, 4'd0, 1'b1);
        cyc(1'b0, 4'b0001); push_exp("uf_clear",  4'b0001, 3'd1, 1'b1, 1'b1, 4'd0, 1'b0);

        // Full FIFO then drain of 8 entries.
        reset_pulse();
        cyc(1'b0, 4'b1100); push_exp("fill_e1", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b1100); push_exp("fill_e2", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b1100); push_exp("full",    4'b0000, 3'd0, 1'b0, 1'b0, 4'd8, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 4'b1100);
            push_exp($sformatf("drain%0d", k), gray_tab[k], 3'(k % 8), (k == 8),
                     ((8 - k) <= 1), 4'(8 - k), 1'b0);
        end

        // Wrap-around with a write-pointer advance overlapping the pops.
        cyc(1'b0, 4'b1010);
        cyc(1'b0, 4'b1010);
        cyc(1'b0, 4'b1010); push_exp("refill",  4'b1100, 3'd0, 1'b0, 1'b0, 4'd4, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_a",  4'b1101, 3'd1, 1'b0, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_b",  4'b1111, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_c",  4'b1110, 3'd3, 1'b0, 1'b0, 4'd5, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_d",  4'b1010, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_e",  4'b1011, 3'd5, 1'b0, 1'b0, 4'd3, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_f",  4'b1001, 3'd6, 1'b0, 1'b0, 4'd2, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_g",  4'b1000, 3'd7, 1'b0, 1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_h",  4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, 4'b0000); push_exp("wrap_uf", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b1);
        cyc(1'b0, 4'b0000); push_exp("wrap_idle", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);

        // Reset in the middle of a drain.
        cyc(1'b0, 4'b0111);
        cyc(1'b0, 4'b0111);
        cyc(1'b0, 4'b0111); push_exp("lvl5",    4'b0000, 3'd0, 1'b0, 1'b0, 4'd5, 1'b0);
        cyc(1'b1, 4'b0111); push_exp("md_pop",  4'b0001, 3'd1, 1'b0, 1'b0, 4'd4, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        push_exp("md_rst_async", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        -> async_ev;
        cyc(1'b1, 4'b0111); push_exp("md_rst_hold", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        inc  = 1'b0;
        wptr = 4'b0000;
        push_exp("md_rel1", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b0000); push_exp("md_rel2", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(1'b0, 4'b0000); push_exp("md_rel3", 4'b0000, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0);

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
